calc_scheduler: RTL
===================

Name: calc_scheduler

Overview:
- Round-robin scheduler sharing one 16-bit integer calculator (ops add/sub/mul/div/mod, 3-bit opcode, registered output) between NREQ requesters.
- Accepts one command at a time over valid/ready and drives the calculator's opcode/operand inputs.
- Waits a fixed pipeline latency, then returns the result tagged with requester id.
- Traps divide/modulo by zero and unsupported opcodes without using the calculator.

Parameters:
- WIDTH, 16, operand/result width
- NREQ, 4, number of requesters (2..8)
- CALC_LAT, 2, cycles from operand-stable to calc_out valid (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester command valid
- req_op  in  3*NREQ  opcode, requester i at [3i+2:3i]
- req_a  in  WIDTH*NREQ  operand A, slice i
- req_b  in  WIDTH*NREQ  operand B, slice i
- req_ready  out  NREQ  one-hot accept strobe
- calc_op  out  3  opcode to calculator
- calc_a  out  WIDTH  operand A to calculator
- calc_b  out  WIDTH  operand B to calculator
- calc_out  in  WIDTH  calculator result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  3  index of requester served
- rsp_data  out  WIDTH  result
- rsp_err  out  1  1 = div/mod by zero or unsupported opcode
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; rr pointer = NREQ-1 (req 0 has first priority). Reset mid-transaction drops it silently; requester must reissue.
- Requester rule: req_valid/op/a/b held stable until its req_ready pulse.
- IDLE: if any req_valid, grant = first set bit searching from pointer+1 upward with wrap. Assert req_ready[grant] combinationally that cycle (cycle 0). Latch op/a/b/id; pointer <= grant.
  - Op 000..100 and not (op in {011,100} with b==0): go EXEC.
  - Op 011/100 with b==0: go RESP; data=0, err=1.
  - Op 110/111, or 101 without POW_EN: go RESP; data=0, err=1.
- EXEC: calc_op/a/b driven from latched registers from cycle 1 and held stable. A down-counter loads CALC_LAT. calc_out is captured on the edge ending cycle CALC_LAT. Then go RESP with err=0.
- RESP: rsp_valid=1; id/data/err stable until the cycle rsp_ready=1, then go IDLE. No acceptance in the handshake cycle; next grant is the following cycle at the earliest.
- Latency, accept to rsp_valid: normal CALC_LAT+1 cycles; trapped 1 cycle.
- calc_op/a/b outside EXEC (and POW): hold last values (no toggling).
- Arithmetic: results are whatever calc_out returns, truncated to WIDTH; no saturation.
- req_ready is never asserted outside IDLE; at most one bit is set.

Optional Feature:
- Macro CALC_SCHED_POW_EN.
- Defined: op 101 = A^B by iterated multiply in state POW.
  - acc <= 1, exp <= B.
  - Each iteration drives calc_op=010, calc_a=acc, calc_b=A, waits CALC_LAT, then acc <= calc_out, exp <= exp-1.
  - Leave at exp==0. B==0 goes straight to RESP with data=1.
  - Result is mod 2^WIDTH, err=0. Latency B*CALC_LAT+1.
- Undefined: op 101 trapped (data=0, err=1); POW state and counters absent.

Test Plan:
- Single req: req1 op=000 a=7 b=5 -> req_ready[1] one cycle; rsp_valid after 3 cycles; id=1, data=12, err=0.
- Fairness: req0..req3 all valid (op=010, a=i+1, b=3), rsp_ready=1 -> grant order 0,1,2,3 and rsp_data 3,6,9,12. Then re-raise req0 and req2 -> order 0,2.
- Div by zero: req2 op=011 a=9 b=0 -> rsp 1 cycle after accept, data=0, err=1, calc_* unchanged.
- Backpressure: op=001 a=3 b=5, rsp_ready low 4 cycles -> rsp_valid held, data=0xFFFE stable; req0 valid meanwhile not granted until RESP exits.
- Reset mid-EXEC: rst_n low during CALC_LAT wait -> all outputs 0 immediately; after release, next grant goes to req0 first.
- POW (macro on): op=101 a=3 b=4 -> data=81 after 9 cycles; a=2 b=17 -> data=0; b=0 -> data=1. Macro off -> err=1.

Source files
------------

// File: rtl/calc_scheduler.sv
`timescale 1ns / 1ps
// calc_scheduler
// Round-robin scheduler that shares one integer calculator between NREQ
// requesters. One command is accepted at a time. Each command is either run
// on the calculator or trapped without using it, and the result is returned
// tagged with the id of the requester.
//
// Optional feature: define CALC_SCHED_POW_EN to enable op 101 (A^B). The
// power is computed by repeated multiplies on the shared calculator. When the
// macro is not defined, op 101 is trapped in the same way as other
// unsupported opcodes.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   req_valid      per-requester command valid
//   req_op/a/b     packed per-requester opcode (3b) and operands (WIDTH)
//   req_ready      one-hot accept strobe, combinational, IDLE only
//   calc_op/a/b    registered calculator inputs, held when the calculator is unused
//   calc_out       calculator result, valid CALC_LAT cycles after inputs settle
//   rsp_valid      response valid, held until rsp_ready
//   rsp_ready      consumer accepts the response
//   rsp_id         index of the requester that was served
//   rsp_data       result
//   rsp_err        divide/modulo by zero or unsupported opcode
//   busy           high whenever the scheduler is not idle
module calc_scheduler #(
  parameter int WIDTH    = 16,
  parameter int NREQ     = 4,
  parameter int CALC_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [3*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [2:0]              calc_op,
  output logic [WIDTH-1:0]        calc_a,
  output logic [WIDTH-1:0]        calc_b,
  input  logic [WIDTH-1:0]        calc_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2:0]              rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100,
    OP_POW = 3'b101
  } op_e;

`ifdef CALC_SCHED_POW_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP, S_POW} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
`endif

  localparam int             CW       = $clog2(CALC_LAT + 1);
  localparam logic [CW-1:0]  LAT_LOAD = CW'(CALC_LAT);

  state_e            state;
  logic [2:0]        rr_ptr;
  logic [CW-1:0]     lat_cnt;
`ifdef CALC_SCHED_POW_EN
  logic [WIDTH-1:0]  exp_cnt;
`endif

  logic [2:0]        grant;
  logic              grant_found;
  logic [2:0]        sel_op;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic              trap;

  // Round-robin pick. The first loop finds the lowest valid requester, which
  // is the wrap-around choice. The second loop replaces it with the lowest
  // valid requester above the pointer, if there is one.
  always_comb begin
    // NOTE: give every combinational output a default before any branch, so
    // that no path leaves it unassigned and infers a latch.
    grant       = '0;
    grant_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant       = 3'(i);
        grant_found = 1'b1;
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (3'(i) > rr_ptr)) grant = 3'(i);
    end
  end

  // Select the command fields of the granted requester.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == grant) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Commands that never reach the calculator.
  always_comb begin
    trap = 1'b0;
    case (sel_op)
      OP_ADD, OP_SUB, OP_MUL: trap = 1'b0;
      OP_DIV, OP_MOD:         trap = (sel_b == '0);
`ifdef CALC_SCHED_POW_EN
      OP_POW:                 trap = 1'b0;
`endif
      default:                trap = 1'b1;
    endcase
  end

  // The accept strobe is combinational so the requester sees it in the same
  // cycle as the grant. It is also held low while reset is asserted.
  assign req_ready = (rst_n && (state == S_IDLE) && grant_found)
                     ? (NREQ'(1) << grant) : '0;

  // NOTE: all state uses non-blocking assignments. Every register then
  // updates from the values present before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= 3'(NREQ - 1);
      lat_cnt   <= '0;
      calc_op   <= '0;
      calc_a    <= '0;
      calc_b    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
`ifdef CALC_SCHED_POW_EN
      exp_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            rr_ptr <= grant;
            rsp_id <= grant;
            busy   <= 1'b1;
            if (trap) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
            end
`ifdef CALC_SCHED_POW_EN
            else if (sel_op == OP_POW) begin
              if (sel_b == '0) begin
                state     <= S_RESP;
                rsp_valid <= 1'b1;
                rsp_data  <= WIDTH'(1);
                rsp_err   <= 1'b0;
              end else begin
                // calc_a is the running product. It starts at 1 and is
                // multiplied by A once per iteration.
                state   <= S_POW;
                calc_op <= OP_MUL;
                calc_a  <= WIDTH'(1);
                calc_b  <= sel_a;
                exp_cnt <= sel_b;
                lat_cnt <= LAT_LOAD;
              end
            end
`endif
            else begin
              state   <= S_EXEC;
              calc_op <= sel_op;
              calc_a  <= sel_a;
              calc_b  <= sel_b;
              lat_cnt <= LAT_LOAD;
            end
          end
        end

        S_EXEC: begin
          // The operands first drive the calculator in the cycle after the
          // accept, so calc_out is valid while the count shows 1.
          if (lat_cnt == CW'(1)) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= calc_out;
            rsp_err   <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end

`ifdef CALC_SCHED_POW_EN
        S_POW: begin
          if (lat_cnt == CW'(1)) begin
            if (exp_cnt == WIDTH'(1)) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= calc_out;
              rsp_err   <= 1'b0;
            end else begin
              calc_a  <= calc_out;
              exp_cnt <= exp_cnt - WIDTH'(1);
              lat_cnt <= LAT_LOAD;
            end
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end
`endif

        S_RESP: begin
          // Nothing is granted in the handshake cycle. The next grant can
          // happen in the following IDLE cycle.
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
